prog_ctr_fetch: RTL and testbench

Program counter and instruction-fetch stage directly upstream of the ALU. It holds the D-bit program counter, drives the instruction ROM address and the ALU's prog_ctr input, and loads branch targets produced by the ALU's branch-not-zero operation. A small start/run/halt state machine sequences program execution and reports completion to the testbench or host.

---
 rtl/prog_ctr_fetch.sv | 105 ++++++++++
 tb/tb_prog_ctr_fetch.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/prog_ctr_fetch.sv
// rtl/prog_ctr_fetch.sv - program counter, instruction fetch and start/run/halt sequencer
// Optional RUN cycle counter is built only when FETCH_CYC_CNT_EN is defined.
module prog_ctr_fetch #(
    parameter int D  = 12,
    parameter int IW = 9,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [D-1:0]  start_addr,
    input  logic          stall,
    input  logic          halt_i,
    input  logic          branch_en,
    input  logic [8:0]    branch_tgt,
    input  logic [IW-1:0] instr_i,
    output logic [D-1:0]  imem_addr,
    output logic [D-1:0]  prog_ctr,
    output logic [IW-1:0] instr_o,
    output logic          valid_o,
    output logic          done,
    output logic [CW-1:0] cyc_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t       state, state_nxt;
    logic [D-1:0] pc, pc_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            pc    <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
        end
    end

    // Branch targets are page-relative: only the low 9 bits come from the ALU.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_nxt = S_RUN;
                    pc_nxt    = start_addr;
                end
            end
            S_RUN: begin
                if (!stall) begin
                    if (halt_i) begin
                        state_nxt = S_HALT;
                    end else if (branch_en) begin
                        pc_nxt = {pc[D-1:9], branch_tgt};
                    end else if (&pc) begin
                        state_nxt = S_HALT;
                    end else begin
                        pc_nxt = pc + D'(1);
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
                pc_nxt    = '0;
            end
        endcase
    end

    assign imem_addr = pc;
    assign prog_ctr  = pc;
    assign valid_o   = (state == S_RUN);
    assign done      = (state == S_HALT);
    assign instr_o   = valid_o ? instr_i : '0;

`ifdef FETCH_CYC_CNT_EN
    logic          run_step;
    logic          start_acc;
    logic [CW-1:0] cnt;

    assign run_step  = (state == S_RUN) && !stall;
    assign start_acc = (state != S_RUN) && start;

    // Saturating count of unstalled RUN cycles, halting cycle included.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (start_acc) begin
            cnt <= '0;
        end else if (run_step && !(&cnt)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign cyc_cnt = cnt;
`else
    assign cyc_cnt = '0;
`endif

endmodule

// File: tb/tb_prog_ctr_fetch.sv
// tb/tb_prog_ctr_fetch.sv - directed vector table plus randomized reference-model bench
module tb_prog_ctr_fetch;

    localparam int D  = 12;
    localparam int IW = 9;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [D-1:0]  start_addr = '0;
    logic          stall = 1'b0;
    logic          halt_i = 1'b0;
    logic          branch_en = 1'b0;
    logic [8:0]    branch_tgt = '0;
    logic [IW-1:0] instr_i;
    logic [D-1:0]  imem_addr;
    logic [D-1:0]  prog_ctr;
    logic [IW-1:0] instr_o;
    logic          valid_o;
    logic          done;
    logic [CW-1:0] cyc_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] rom(input logic [D-1:0] a);
        return a[8:0] ^ 9'h0A5 ^ {6'b0, a[11:9]};
    endfunction

    assign instr_i = rom(imem_addr);

    prog_ctr_fetch #(.D(D), .IW(IW), .CW(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .stall      (stall),
        .halt_i     (halt_i),
        .branch_en  (branch_en),
        .branch_tgt (branch_tgt),
        .instr_i    (instr_i),
        .imem_addr  (imem_addr),
        .prog_ctr   (prog_ctr),
        .instr_o    (instr_o),
        .valid_o    (valid_o),
        .done       (done),
        .cyc_cnt    (cyc_cnt)
    );

    typedef struct {
        logic        r;
        logic        s;
        logic [11:0] sa;
        logic        st;
        logic        h;
        logic        b;
        logic [8:0]  t;
        logic [11:0] pc;
        logic        v;
        logic        d;
        int          cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, s, input logic [11:0] sa,
                                input logic st, h, b, input logic [8:0] t,
                                input logic [11:0] pc, input logic v, d, input int cnt);
        vec_t x;
        x.r = r; x.s = s; x.sa = sa; x.st = st; x.h = h; x.b = b; x.t = t;
        x.pc = pc; x.v = v; x.d = d; x.cnt = cnt;
        return x;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
    endtask

    task automatic apply(input logic r, s, input logic [11:0] sa,
                         input logic st, h, b, input logic [8:0] t);
        rst_n = r; start = s; start_addr = sa; stall = st;
        halt_i = h; branch_en = b; branch_tgt = t;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input int idx, input logic [11:0] epc,
                             input logic ev, input logic ed, input int ecnt);
        int c;
`ifdef FETCH_CYC_CNT_EN
        c = ecnt;
`else
        c = 0;
`endif
        chk({tag, "_prog_ctr"}, idx, 32'(prog_ctr), 32'(epc));
        chk({tag, "_imem_addr"}, idx, 32'(imem_addr), 32'(epc));
        chk({tag, "_valid_o"}, idx, 32'(valid_o), 32'(ev));
        chk({tag, "_done"}, idx, 32'(done), 32'(ed));
        chk({tag, "_instr_o"}, idx, 32'(instr_o), ev ? 32'(rom(epc)) : 32'd0);
        chk({tag, "_cyc_cnt"}, idx, 32'(cyc_cnt), 32'(c));
    endtask

    // Reference model: plain integer bookkeeping of the fetch rules.
    int m_st;   // 0 idle, 1 run, 2 halt
    int m_pc;
    int m_cnt;

    task automatic model_step(input logic r, s, input logic [11:0] sa,
                              input logic st, h, b, input logic [8:0] t);
        if (!r) begin
            m_st = 0; m_pc = 0; m_cnt = 0;
        end else if (m_st != 1) begin
            if (s) begin
                m_st = 1; m_pc = int'(sa); m_cnt = 0;
            end
        end else if (!st) begin
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
            if (h)                 m_st = 2;
            else if (b)            m_pc = (m_pc / 512) * 512 + int'(t);
            else if (m_pc == 4095) m_st = 2;
            else                   m_pc = m_pc + 1;
        end
    endtask

    initial begin
        // rst, start, addr, stall, halt, br, tgt | pc, valid, done, cnt
        tbl.push_back(mk(0,0,12'h000,0,0,0,9'h000, 12'h000,0,0,0));
        tbl.push_back(mk(1,0,12'h000,0,1,1,9'h1FF, 12'h000,0,0,0));
        tbl.push_back(mk(1,1,12'h010,0,0,0,9'h000, 12'h010,1,0,0));
        tbl.push_back(mk(1,0,12'h000,0,0,0,9'h000, 12'h011,1,0,1));
        tbl.push_back(mk(1,0,12'h000,0,0,0,9'h000, 12'h012,1,0,2));
        tbl.push_back(mk(1,1,12'h500,0,0,0,9'h000, 12'h013,1,0,3));
        tbl.push_back(mk(1,0,12'h000,0,0,0,9'h000, 12'h014,1,0,4));
        tbl.push_back(mk(1,0,12'h000,0,1,0,9'h000, 12'h014,0,1,5));
        tbl.push_back(mk(1,0,12'h000,1,1,1,9'h005, 12'h014,0,1,5));
        tbl.push_back(mk(1,1,12'h205,0,0,0,9'h000, 12'h205,1,0,0));
        tbl.push_back(mk(1,0,12'h000,0,0,1,9'h033, 12'h233,1,0,1));
        tbl.push_back(mk(1,0,12'h000,0,1,0,9'h000, 12'h233,0,1,2));
        tbl.push_back(mk(1,1,12'h020,0,0,0,9'h000, 12'h020,1,0,0));
        tbl.push_back(mk(1,0,12'h000,1,1,1,9'h0AA, 12'h020,1,0,0));
        tbl.push_back(mk(1,0,12'h000,1,1,1,9'h0AA, 12'h020,1,0,0));
        tbl.push_back(mk(1,0,12'h000,1,1,1,9'h0AA, 12'h020,1,0,0));
        tbl.push_back(mk(1,0,12'h000,0,0,0,9'h000, 12'h021,1,0,1));
        tbl.push_back(mk(1,0,12'h000,0,0,1,9'h040, 12'h040,1,0,2));
        tbl.push_back(mk(1,0,12'h000,0,1,1,9'h077, 12'h040,0,1,3));
        tbl.push_back(mk(1,1,12'h3FF,0,0,0,9'h000, 12'h3FF,1,0,0));
        tbl.push_back(mk(1,0,12'h000,0,0,1,9'h000, 12'h200,1,0,1));
        tbl.push_back(mk(1,0,12'h000,0,1,0,9'h000, 12'h200,0,1,2));
        tbl.push_back(mk(1,1,12'hFFE,0,0,0,9'h000, 12'hFFE,1,0,0));
        tbl.push_back(mk(1,0,12'h000,0,0,0,9'h000, 12'hFFF,1,0,1));
        tbl.push_back(mk(1,0,12'h000,0,0,0,9'h000, 12'hFFF,0,1,2));
        tbl.push_back(mk(1,0,12'h000,0,0,0,9'h000, 12'hFFF,0,1,2));
        tbl.push_back(mk(1,1,12'h123,0,0,0,9'h000, 12'h123,1,0,0));
        tbl.push_back(mk(0,1,12'h456,1,0,0,9'h000, 12'h000,0,0,0));
        tbl.push_back(mk(1,1,12'h100,0,0,0,9'h000, 12'h100,1,0,0));
        tbl.push_back(mk(1,0,12'h000,0,1,0,9'h000, 12'h100,0,1,1));
        tbl.push_back(mk(1,1,12'h300,0,0,0,9'h000, 12'h300,1,0,0));
        tbl.push_back(mk(1,0,12'h000,0,0,0,9'h000, 12'h301,1,0,1));
        tbl.push_back(mk(0,0,12'h000,1,0,0,9'h000, 12'h000,0,0,0));

        foreach (tbl[i]) begin
            apply(tbl[i].r, tbl[i].s, tbl[i].sa, tbl[i].st, tbl[i].h, tbl[i].b, tbl[i].t);
            check_out("vec", i, tbl[i].pc, tbl[i].v, tbl[i].d, tbl[i].cnt);
        end

        // Randomized run against the reference model, starting from reset.
        m_st = 0; m_pc = 0; m_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            logic        r, s, st, h, b;
            logic [11:0] sa;
            logic [8:0]  t;
            r  = (i == 0) ? 1'b0 : ($urandom_range(0, 299) != 0);
            s  = ($urandom_range(0, 11) == 0);
            sa = ($urandom_range(0, 3) == 0) ? 12'(12'hFF0 + $urandom_range(0, 15))
                                             : 12'($urandom);
            st = ($urandom_range(0, 3) == 0);
            h  = ($urandom_range(0, 39) == 0);
            b  = ($urandom_range(0, 7) == 0);
            t  = 9'($urandom);
            apply(r, s, sa, st, h, b, t);
            model_step(r, s, sa, st, h, b, t);
            check_out("rnd", i, 12'(m_pc), (m_st == 1), (m_st == 2), m_cnt);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
